jk_bist_ctrl: RTL and testbench

Built-in self-test controller for the `jkff` cell. It sits directly upstream of the flop: it drives `j`/`k` and the flop's reset, then consumes `q` back. It applies a pseudo-random J/K sequence from an 8-bit LFSR and checks every `q` against an internal golden model. Pass/fail, the first failing step and a mismatch count are reported to the test harness.

---
 rtl/jk_bist_pkg.sv | 35 +++
 rtl/jk_lfsr8.sv | 43 ++++
 rtl/jk_bist_ctrl.sv | 156 +++++++++++++++
 tb/tb_jk_bist_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/jk_bist_pkg.sv
// jk_bist_pkg
//   Shared types and helpers for the jkff built-in self-test controller.
//   - state_t    : controller FSM states
//   - JK_* codes : {j,k} drive encodings
//   - LFSR_TAPS  : feedback taps of the 8-bit Fibonacci LFSR (bits 7,5,4,3)
//   - jk_next()  : next-state rule of a JK flop, used as the golden model
package jk_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic jk_next(input logic q, input logic [1:0] jk);
    logic q_n;
    case (jk)
      JK_HOLD: q_n = q;
      JK_RST:  q_n = 1'b0;
      JK_SET:  q_n = 1'b1;
      default: q_n = ~q;
    endcase
    return q_n;
  endfunction

endpackage

// File: rtl/jk_lfsr8.sv
// jk_lfsr8
//   8-bit Fibonacci LFSR, shift-left, new bit0 = parity of the tapped bits.
//   Ports:
//     clk   - clock
//     rst   - synchronous active-high reset (register cleared)
//     load  - load seed (takes priority over en)
//     seed  - value loaded when load is high
//     en    - advance one step
//     state - current register contents
module jk_lfsr8
  import jk_bist_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       en,
  output logic [7:0] state
);

  logic [7:0] state_q;
  logic [7:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (en) begin
      state_d = {state_q[6:0], ^(state_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= 8'h00;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/jk_bist_ctrl.sv
// jk_bist_ctrl
//   BIST controller for a jkff cell: resets the flop, drives N_STEPS
//   pseudo-random J/K pairs from an LFSR and checks q against a golden model
//   with one cycle of check latency (the DRAIN cycle checks the last step).
//   Ports:
//     clk, rst        - clock, synchronous active-high reset
//     start           - run request, sampled only in IDLE
//     dut_rst         - reset to the flop under test (high in INIT)
//     j_out, k_out    - J/K drive to the flop
//     q_in            - flop output
//     busy            - high in INIT, RUN and DRAIN
//     done            - one-cycle pulse in DONE
//     pass            - result of last run, held until next accepted start
//     fail_idx        - steps applied when the first mismatch was seen
//     err_cnt         - mismatch count of this run, saturating at 255
module jk_bist_ctrl
  import jk_bist_pkg::*;
#(
  parameter int unsigned N_STEPS = 32,
  parameter logic [7:0]  SEED    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       dut_rst,
  output logic       j_out,
  output logic       k_out,
  input  logic       q_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_idx,
  output logic [7:0] err_cnt
);

  // An all-zero seed would lock the LFSR up.
  localparam logic [7:0] SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [7:0] N_STEPS_B = 8'(N_STEPS);
  localparam logic [7:0] LAST_STEP = 8'(N_STEPS - 1);

  state_t     state_q, state_d;
  logic       exp_q_q, exp_q_d;
  logic [7:0] step_q, step_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [7:0] fail_idx_q, fail_idx_d;
  logic       first_err_q, first_err_d;
  logic       pass_q, pass_d;

  logic [7:0] lfsr_state;
  logic [1:0] jk_drive;
  logic       cmp_en;
  logic       mismatch;
  logic       unused_lfsr_hi;

  jk_lfsr8 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (state_q == INIT),
    .seed  (SEED_EFF),
    .en    (state_q == RUN),
    .state (lfsr_state)
  );

  // Only the low two bits drive J/K; the rest exist for the feedback.
  assign unused_lfsr_hi = ^lfsr_state[7:2];

  assign jk_drive = (state_q == RUN) ? lfsr_state[1:0] : JK_HOLD;
  assign cmp_en   = (state_q == RUN) || (state_q == DRAIN);
  assign mismatch = cmp_en && (q_in != exp_q_q);

  always_comb begin
    state_d     = state_q;
    exp_q_d     = exp_q_q;
    step_d      = step_q;
    err_cnt_d   = err_cnt_q;
    fail_idx_d  = fail_idx_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = INIT;
          pass_d      = 1'b0;
          err_cnt_d   = 8'h00;
          fail_idx_d  = 8'h00;
          first_err_d = 1'b0;
        end
      end
      INIT: begin
        exp_q_d = 1'b0;
        step_d  = 8'h00;
        state_d = RUN;
      end
      RUN: begin
        exp_q_d = jk_next(exp_q_q, jk_drive);
        step_d  = step_q + 8'd1;
        if (step_q == LAST_STEP) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Register the verdict here so pass is already valid while done is high;
        // the DRAIN compare is folded in directly.
        pass_d  = (err_cnt_q == 8'h00) && !mismatch;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (mismatch) begin
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
      if (!first_err_q) begin
        first_err_d = 1'b1;
        fail_idx_d  = (state_q == DRAIN) ? N_STEPS_B : step_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      exp_q_q     <= 1'b0;
      step_q      <= 8'h00;
      err_cnt_q   <= 8'h00;
      fail_idx_q  <= 8'h00;
      first_err_q <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q_q     <= exp_q_d;
      step_q      <= step_d;
      err_cnt_q   <= err_cnt_d;
      fail_idx_q  <= fail_idx_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
    end
  end

  assign dut_rst  = (state_q == INIT);
  assign j_out    = jk_drive[1];
  assign k_out    = jk_drive[0];
  assign busy     = (state_q == INIT) || (state_q == RUN) || (state_q == DRAIN);
  assign done     = (state_q == DONE);
  assign pass     = pass_q;
  assign fail_idx = fail_idx_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_jk_bist_ctrl.sv
// tb_jk_bist_ctrl
//   Directed bench: a behavioural jkff (optionally faulted) closes the loop
//   around the controller; a second instance with SEED=0 runs in parallel.
module tb_jk_bist_ctrl;
  import jk_bist_pkg::*;

  localparam int N = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  int         mode = 0;  // 0 good flop, 1 q stuck at 0, 2 q inverted

  logic       dut_rst, j_out, k_out, q_in, busy, done, pass;
  logic [7:0] fail_idx, err_cnt;
  logic       dut_rst_z, j_z, k_z, q_z, busy_z, done_z, pass_z;
  logic [7:0] fail_idx_z, err_cnt_z;
  logic       fq, fq_z;

  int checks = 0;
  int errors = 0;

  int busy_n, done_at, done_n, busy_nz, done_at_z;
  logic pass_at_done, pass_at_done_z;

  always #5 clk = ~clk;

  jk_bist_ctrl #(.N_STEPS(N), .SEED(8'hA5)) u_dut (
    .clk(clk), .rst(rst), .start(start), .dut_rst(dut_rst),
    .j_out(j_out), .k_out(k_out), .q_in(q_in), .busy(busy), .done(done),
    .pass(pass), .fail_idx(fail_idx), .err_cnt(err_cnt)
  );

  jk_bist_ctrl #(.N_STEPS(N), .SEED(8'h00)) u_dz (
    .clk(clk), .rst(rst), .start(start), .dut_rst(dut_rst_z),
    .j_out(j_z), .k_out(k_z), .q_in(q_z), .busy(busy_z), .done(done_z),
    .pass(pass_z), .fail_idx(fail_idx_z), .err_cnt(err_cnt_z)
  );

  // Behavioural flops under test, written from the JK truth table.
  always_ff @(posedge clk) begin
    if (dut_rst) fq <= 1'b0;
    else case ({j_out, k_out})
      2'b01:   fq <= 1'b0;
      2'b10:   fq <= 1'b1;
      2'b11:   fq <= ~fq;
      default: fq <= fq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (dut_rst_z) fq_z <= 1'b0;
    else case ({j_z, k_z})
      2'b01:   fq_z <= 1'b0;
      2'b10:   fq_z <= 1'b1;
      2'b11:   fq_z <= ~fq_z;
      default: fq_z <= fq_z;
    endcase
  end

  assign q_in = (mode == 1) ? 1'b0 : (mode == 2) ? ~fq : fq;
  assign q_z  = fq_z;

  function automatic logic [7:0] lf_adv(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic jk_rule(input logic q, input logic [1:0] jk);
    if (jk == 2'b01) return 1'b0;
    if (jk == 2'b10) return 1'b1;
    if (jk == 2'b11) return ~q;
    return q;
  endfunction

  // Number of compares (32 RUN + DRAIN) where the golden value is 1.
  function automatic int stuck0_count();
    logic [7:0] l = 8'hA5;
    logic e = 1'b0;
    int n = 0;
    for (int s = 0; s < N; s++) begin
      if (e) n++;
      e = jk_rule(e, l[1:0]);
      l = lf_adv(l);
    end
    if (e) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one start, then watch 60 cycles; cycle c=1 is INIT.
  task automatic do_run(input int m, input bit hold, input bit trace);
    logic [7:0] lf_a, lf_z;
    lf_a = 8'hA5;
    lf_z = 8'h01;
    mode = m;
    busy_n = 0; done_at = 0; done_n = 0; busy_nz = 0; done_at_z = 0;
    pass_at_done = 1'bx; pass_at_done_z = 1'bx;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; if (!hold) start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (busy_z) busy_nz++;
      if (done) begin
        done_n++;
        if (done_at == 0) begin done_at = c; pass_at_done = pass; end
        start = 1'b0;
      end
      if (done_z && done_at_z == 0) begin done_at_z = c; pass_at_done_z = pass_z; end
      if (c == 1) begin
        chk("init_dut_rst", 32'(dut_rst), 32'd1);
        chk("init_pass_clr", 32'(pass), 32'd0);
        chk("init_err_clr", 32'(err_cnt), 32'd0);
      end
      if (trace) begin
        if (c == 1) chk("init_jk", 32'({j_out, k_out}), 32'd0);
        if (c == 2) chk("seed_jk0", 32'({j_out, k_out}), 32'h1);
        if (c == 3) chk("seed_jk1", 32'({j_out, k_out}), 32'h2);
        if (c == 3) chk("seed_expq0", 32'(u_dut.exp_q_q), 32'd0);
        if (c == 4) chk("seed_expq1", 32'(u_dut.exp_q_q), 32'd1);
        if (c >= 2 && c <= N + 1) begin
          chk("run_jk", 32'({j_out, k_out}), 32'(lf_a[1:0]));
          chk("seed0_jk", 32'({j_z, k_z}), 32'(lf_z[1:0]));
          lf_a = lf_adv(lf_a);
          lf_z = lf_adv(lf_z);
        end
        if (c == N + 2) chk("drain_jk", 32'({j_out, k_out}), 32'd0);
      end
    end
    start = 1'b0;
    $display("run mode=%0d hold=%0b busy=%0d done_at=%0d dones=%0d pass=%0b err_cnt=%0d fail_idx=%0d",
             m, hold, busy_n, done_at, done_n, pass_at_done, err_cnt, fail_idx);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_dut_rst", 32'(dut_rst), 32'd0);
    chk("rst_jk", 32'({j_out, k_out}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_fail_idx", 32'(fail_idx), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);

    // Shared golden-model function
    chk("jk_next_hold", 32'(jk_next(1'b1, JK_HOLD)), 32'd1);
    chk("jk_next_rst", 32'(jk_next(1'b1, JK_RST)), 32'd0);
    chk("jk_next_set", 32'(jk_next(1'b0, JK_SET)), 32'd1);
    chk("jk_next_tgl", 32'(jk_next(1'b1, JK_TGL)), 32'd0);

    // Good flop with full J/K trace; SEED=0 instance checked against seed 01
    do_run(0, 1'b0, 1'b1);
    chk("good_busy", busy_n, 32'd34);
    chk("good_done_at", done_at, 32'd35);
    chk("good_dones", done_n, 32'd1);
    chk("good_pass", 32'(pass_at_done), 32'd1);
    chk("good_err", 32'(err_cnt), 32'd0);
    chk("good_fidx", 32'(fail_idx), 32'd0);
    chk("seed0_busy", busy_nz, 32'd34);
    chk("seed0_done_at", done_at_z, 32'd35);
    chk("seed0_pass", 32'(pass_at_done_z), 32'd1);
    repeat (3) @(negedge clk);
    chk("pass_held", 32'(pass), 32'd1);

    // q stuck at 0: first mismatch after step 1 sets the golden value
    do_run(1, 1'b0, 1'b0);
    chk("stuck_pass", 32'(pass_at_done), 32'd0);
    chk("stuck_fidx", 32'(fail_idx), 32'd2);
    chk("stuck_err", 32'(err_cnt), 32'(stuck0_count()));

    // q inverted: every compare fails, 32 RUN + 1 DRAIN
    do_run(2, 1'b0, 1'b0);
    chk("inv_pass", 32'(pass_at_done), 32'd0);
    chk("inv_fidx", 32'(fail_idx), 32'd0);
    chk("inv_err", 32'(err_cnt), 32'd33);

    // Reset mid-RUN
    mode = 2;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_err", 32'(err_cnt), 32'd6);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_state", 32'(u_dut.state_q), 32'(IDLE));
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_jk", 32'({j_out, k_out}), 32'd0);
    chk("midrst_dut_rst", 32'(dut_rst), 32'd0);
    chk("midrst_err", 32'(err_cnt), 32'd0);
    chk("midrst_fidx", 32'(fail_idx), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    $display("midrun reset: busy=%0b err_cnt=%0d", busy, err_cnt);
    do_run(0, 1'b0, 1'b0);
    chk("rerun_pass", 32'(pass_at_done), 32'd1);
    chk("rerun_done_at", done_at, 32'd35);

    // start held high through the run: no restart, single done
    do_run(0, 1'b1, 1'b0);
    chk("hold_dones", done_n, 32'd1);
    chk("hold_busy", busy_n, 32'd34);
    chk("hold_pass", 32'(pass_at_done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
